capture_ctrl: RTL and testbench

//  Sequencer for the analyzer's circular sample buffer (write_mem). Arms a capture, resets
//  the buffer, fills it with pre-trigger history until primed, waits for a trigger, writes a

---
 rtl/capture_ctrl.sv | 114 +++++++++++
 tb/tb_capture_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences the circular sample buffer through arm, pre-trigger fill,
//   trigger, post-trigger writes and freeze, then streams all 2**ADDR_WIDTH samples oldest first.
// Latency: state changes one cycle after the qualifying input; done pulses one cycle after the last accept.
// Backpressure: readout holds raddr/rd_valid until rd_ready; nothing is dropped and there is no timeout.
// Ports: arm/trigger/post_count  capture control from host
//        waddr/primed            status from write_mem
//        buf_reset/write_enable  control to write_mem
//        raddr/rd_valid/rd_ready/rd_is_trig  readout stream
//        trig_addr/busy/done     status to host
module capture_ctrl #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  trigger,
   input  logic [ADDR_WIDTH-1:0] post_count,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  primed,
   output logic                  buf_reset,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  rd_is_trig,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      READ  = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] rd_cnt;
   logic [ADDR_WIDTH-1:0] post_cnt;
   logic                  rd_accept;
   logic                  rd_last;

   assign rd_accept = rd_valid & rd_ready;
   assign rd_last   = rd_accept && (rd_cnt == LAST_IDX);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         trig_addr <= '0;
         rd_cnt    <= '0;
         post_cnt  <= '0;
         done      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= rd_last;
         // Holding rd_cnt at zero outside READ gives a clean start on every entry.
         if (state != READ) begin
            rd_cnt <= '0;
         end else if (rd_accept) begin
            rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
         end
         if (state == ARMED && trigger) begin
            // The sample written this very cycle is the trigger sample.
            trig_addr <= waddr;
            post_cnt  <= post_count;
         end else if (state == POST) begin
            post_cnt <= post_cnt - ADDR_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      buf_reset    = 1'b0;
      write_enable = 1'b0;
      raddr        = '0;
      rd_valid     = 1'b0;
      rd_is_trig   = 1'b0;
      case (state)
         IDLE: begin
            // write_mem sees the system reset directly, so no pulse while reset is high.
            buf_reset = arm & ~reset;
            if (arm) state_nxt = FILL;
         end
         FILL: begin
            write_enable = 1'b1;
            if (primed) state_nxt = ARMED;
         end
         ARMED: begin
            write_enable = 1'b1;
            if (trigger) state_nxt = (post_count == '0) ? READ : POST;
         end
         POST: begin
            write_enable = 1'b1;
            // The write in this cycle is the last post-trigger sample.
            if (post_cnt == ADDR_WIDTH'(1)) state_nxt = READ;
         end
         READ: begin
            // Writes are stopped, so waddr is frozen on the oldest sample.
            raddr      = waddr + rd_cnt;
            rd_valid   = 1'b1;
            rd_is_trig = (raddr == trig_addr);
            if (rd_ready && rd_cnt == LAST_IDX) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;

   localparam int AW = 4;
   localparam int MS = 16;

   logic          clk = 1'b0;
   logic          reset, arm, trigger, primed, rd_ready;
   logic [AW-1:0] post_count, waddr;
   logic          buf_reset, write_enable, rd_valid, rd_is_trig, busy, done;
   logic [AW-1:0] trig_addr, raddr;

   int n_cmp = 0;
   int n_bad = 0;

   // Environment: behavioural write_mem storing a unique id per written sample.
   logic [15:0] mem [MS];
   int unsigned wcount = 0;
   int unsigned wq[$];

   // Reference state for the capture in flight.
   int unsigned trig_id;
   int          cur_post;
   int          cur_tgt;
   int          exp_end;

   capture_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .arm(arm), .trigger(trigger),
      .post_count(post_count), .waddr(waddr), .primed(primed),
      .buf_reset(buf_reset), .write_enable(write_enable), .trig_addr(trig_addr),
      .raddr(raddr), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_is_trig(rd_is_trig), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset || buf_reset) begin
         waddr  <= '0;
         primed <= 1'b0;
      end else if (write_enable) begin
         mem[waddr] <= wcount[15:0];
         wq.push_back(wcount);
         wcount <= wcount + 1;
         waddr  <= waddr + 1'b1;
         if (waddr == AW'(MS - 1)) primed <= 1'b1;
      end
   end

   task automatic test_reset();
      reset = 1'b1; arm = 1'b1; trigger = 1'b0; rd_ready = 1'b0; post_count = '0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({busy, write_enable, rd_valid, done, buf_reset, trig_addr} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: busy=%b we=%b vld=%b done=%b bufrst=%b taddr=%0d, want all 0",
                  busy, write_enable, rd_valid, done, buf_reset, trig_addr);
      end
      @(negedge clk); reset = 1'b0; arm = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic wait_primed();
      for (int i = 0; i < 40 && primed !== 1'b1; i++) @(negedge clk);
      n_cmp++;
      if (primed !== 1'b1) begin
         n_bad++; $display("FAIL prime_timeout: primed=%b want 1", primed);
      end
      @(negedge clk);
   endtask

   task automatic start_capture();
      @(negedge clk); arm = 1'b1;
      #1;
      n_cmp++;
      if ({buf_reset, busy} !== 2'b10) begin
         n_bad++; $display("FAIL arm_bufrst: bufrst=%b busy=%b want 1 0", buf_reset, busy);
      end
      @(negedge clk); arm = 1'b0;
      wait_primed();
   endtask

   // Arm, then walk the fill cycle by cycle; triggers during fill must be ignored.
   task automatic test_fill_arm();
      @(negedge clk); arm = 1'b1;
      #1;
      n_cmp++;
      if ({buf_reset, busy} !== 2'b10) begin
         n_bad++; $display("FAIL fill_arm: bufrst=%b busy=%b want 1 0", buf_reset, busy);
      end
      @(negedge clk); arm = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         trigger = (k == 3 || k == 10);
         #1;
         n_cmp++;
         if ({write_enable, busy, primed, waddr} !== {1'b1, 1'b1, k == 16, 4'(k)}) begin
            n_bad++;
            $display("FAIL fill_step%0d: we=%b busy=%b primed=%b waddr=%0d want 1 1 %0d %0d",
                     k, write_enable, busy, primed, waddr, k == 16, k % MS);
         end
         @(negedge clk);
      end
      trigger = 1'b0;
   endtask

   // Trigger when waddr reaches tgt, then count the post-trigger writes.
   task automatic capture(input int tgt, input int post, input bit noise);
      int nw;
      for (int i = 0; i < 20 && waddr !== AW'(tgt); i++) @(negedge clk);
      cur_tgt = tgt; cur_post = post; exp_end = (tgt + post + 1) % MS;
      post_count = AW'(post); trigger = 1'b1; trig_id = wcount;
      #1;
      n_cmp++;
      if ({write_enable, waddr} !== {1'b1, AW'(tgt)}) begin
         n_bad++; $display("FAIL trig_setup: we=%b waddr=%0d want 1 %0d", write_enable, waddr, tgt);
      end
      @(negedge clk); trigger = 1'b0; post_count = AW'($urandom_range(0, MS - 1));
      nw = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (write_enable !== 1'b1) break;
         nw++;
         @(negedge clk);
         trigger = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      trigger = 1'b0;
      n_cmp++;
      if (nw != post) begin
         n_bad++; $display("FAIL post_writes: got %0d want %0d", nw, post);
      end
      n_cmp++;
      if ({rd_valid, waddr, trig_addr} !== {1'b1, AW'(exp_end), AW'(tgt)}) begin
         n_bad++;
         $display("FAIL read_entry: vld=%b waddr=%0d taddr=%0d want 1 %0d %0d",
                  rd_valid, waddr, trig_addr, exp_end, tgt);
      end
   endtask

   // Reference: the stream is the last MS written ids, trigger at index MS-1-post.
   task automatic readout(input bit rnd_ready, input bit arm_on_done);
      int unsigned exp_ids[MS];
      int beats = 0;
      for (int i = 0; i < MS; i++) exp_ids[i] = wq[wq.size() - MS + i];
      for (int c = 0; c < 400 && beats < MS; c++) begin
         @(negedge clk);
         rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         n_cmp++;
         if ({rd_valid, raddr} !== {1'b1, AW'((exp_end + beats) % MS)}) begin
            n_bad++;
            $display("FAIL rd_addr beat%0d: vld=%b raddr=%0d want 1 %0d",
                     beats, rd_valid, raddr, (exp_end + beats) % MS);
         end
         if (rd_ready) begin
            n_cmp++;
            if ({mem[raddr], rd_is_trig} !== {exp_ids[beats][15:0], beats == MS - 1 - cur_post}) begin
               n_bad++;
               $display("FAIL rd_data beat%0d: id=%0d is_trig=%b want %0d %b", beats, mem[raddr],
                        rd_is_trig, exp_ids[beats][15:0], beats == MS - 1 - cur_post);
            end
            beats++;
         end
      end
      n_cmp++;
      if (beats != MS) begin
         n_bad++; $display("FAIL rd_timeout: accepted %0d want %0d", beats, MS);
      end
      @(negedge clk); rd_ready = 1'b0; arm = arm_on_done;
      #1;
      n_cmp++;
      if ({done, busy, rd_valid, buf_reset} !== {1'b1, 1'b0, 1'b0, arm_on_done}) begin
         n_bad++;
         $display("FAIL done_pulse: done=%b busy=%b vld=%b bufrst=%b want 1 0 0 %b",
                  done, busy, rd_valid, buf_reset, arm_on_done);
      end
      @(negedge clk); arm = 1'b0;
      #1;
      n_cmp++;
      if ({done, busy} !== {1'b0, arm_on_done}) begin
         n_bad++; $display("FAIL done_single: done=%b busy=%b want 0 %b", done, busy, arm_on_done);
      end
   endtask

   task automatic test_post_zero();
      start_capture();
      capture($urandom_range(0, MS - 1), 0, 1'b0);
      readout(1'b0, 1'b0);
   endtask

   // Back-to-back captures re-armed on the done cycle, random stalls, post up to MS-1.
   task automatic test_back_to_back();
      start_capture();
      for (int it = 0; it < 3; it++) begin
         capture($urandom_range(0, MS - 1), (it == 1) ? MS - 1 : $urandom_range(1, MS - 2), 1'b1);
         readout(1'b1, it < 2);
         if (it < 2) wait_primed();
      end
   endtask

   task automatic test_reset_mid();
      start_capture();
      capture($urandom_range(0, MS - 1), 10, 1'b0) ;
      // capture() returns in READ; rerun a capture and cut it short in POST instead.
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      start_capture();
      for (int i = 0; i < 20 && waddr !== 4'd7; i++) @(negedge clk);
      post_count = 4'd10; trigger = 1'b1;
      repeat (3) begin @(negedge clk); trigger = 1'b0; end
      #1;
      n_cmp++;
      if ({write_enable, rd_valid} !== 2'b10) begin
         n_bad++; $display("FAIL in_post: we=%b vld=%b want 1 0", write_enable, rd_valid);
      end
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy, write_enable, rd_valid, done, trig_addr} !== 8'b0) begin
         n_bad++;
         $display("FAIL reset_post: busy=%b we=%b vld=%b done=%b taddr=%0d want all 0",
                  busy, write_enable, rd_valid, done, trig_addr);
      end
      start_capture();
      capture($urandom_range(0, MS - 1), $urandom_range(0, MS - 1), 1'b0);
      rd_ready = 1'b1;
      repeat (3) @(negedge clk);
      rd_ready = 1'b0; reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy, write_enable, rd_valid, done, trig_addr} !== 8'b0) begin
         n_bad++;
         $display("FAIL reset_read: busy=%b we=%b vld=%b done=%b taddr=%0d want all 0",
                  busy, write_enable, rd_valid, done, trig_addr);
      end
   endtask

   initial begin
      test_reset();
      test_fill_arm();
      capture(5, 3, 1'b1);
      readout(1'b0, 1'b0);
      test_post_zero();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
